midi_decoder: RTL and testbench

MIDI_DECODER -- requirements
Module: midi_decoder

---
 rtl/midi_decoder.sv | 184 ++++++++++++++++++
 tb/tb_midi_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/midi_decoder.sv
// MIDI byte-stream decoder: turns UART bytes into channel-voice messages.
// The MIDI package defines the message record carried on the output port.
// Optional feature macro: MIDI_RUNNING_STATUS_EN. When it is defined, the
// status is kept after each message, so further data bytes form new messages.

package MIDI;

    typedef enum logic [2:0] {
        NOTE_OFF         = 3'd0,
        NOTE_ON          = 3'd1,
        POLY_PRESSURE    = 3'd2,
        CONTROL_CHANGE   = 3'd3,
        PROGRAM_CHANGE   = 3'd4,
        CHANNEL_PRESSURE = 3'd5,
        PITCH_BEND       = 3'd6
    } msg_type_e;

    typedef struct packed {
        msg_type_e  message_type;
        logic [3:0] channel;
        logic [7:0] data_byte1;
        logic [7:0] data_byte2;
    } message_t;

endpackage

module midi_decoder #(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
    input  logic           clock_50_000_000,
    input  logic           reset_l,
    input  logic [7:0]     rx_byte,
    input  logic           rx_valid,
    output MIDI::message_t message,
    output logic           message_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA1 = 2'd1;
    localparam logic [1:0] ST_DATA2 = 2'd2;
    localparam logic [1:0] ST_SYSEX = 2'd3;

    logic [1:0]     state_q,         state_d;
    logic [7:0]     status_q,        status_d;
    logic           status_vld_q,    status_vld_d;
    logic [7:0]     data1_q,         data1_d;
    MIDI::message_t message_q,       message_d;
    logic           message_ready_q, message_ready_d;

    logic           emit_s;
    logic [7:0]     emit_b1_s;
    logic [7:0]     emit_b2_s;
    logic           two_byte_s;

    // Maps a channel status high nibble to its message type.
    function automatic MIDI::msg_type_e type_of(input logic [3:0] hi);
        MIDI::msg_type_e t;
        case (hi)
            4'h8:    t = MIDI::NOTE_OFF;
            4'h9:    t = MIDI::NOTE_ON;
            4'hA:    t = MIDI::POLY_PRESSURE;
            4'hB:    t = MIDI::CONTROL_CHANGE;
            4'hC:    t = MIDI::PROGRAM_CHANGE;
            4'hD:    t = MIDI::CHANNEL_PRESSURE;
            4'hE:    t = MIDI::PITCH_BEND;
            default: t = MIDI::NOTE_OFF;
        endcase
        return t;
    endfunction

    // Byte classification, parser state transitions and message assembly.
    always_comb begin
        state_d         = state_q;
        status_d        = status_q;
        status_vld_d    = status_vld_q;
        data1_d         = data1_q;
        message_d       = message_q;
        message_ready_d = 1'b0;
        emit_s          = 1'b0;
        emit_b1_s       = 8'h00;
        emit_b2_s       = 8'h00;
        // Cn (program change) and Dn (channel pressure) carry a single data byte.
        two_byte_s      = (status_q[6:4] != 3'b100) && (status_q[6:4] != 3'b101);

        if (rx_valid) begin
            if (!rx_byte[7]) begin
                // Data byte: its meaning depends on where the parser is.
                case (state_q)
                    ST_IDLE, ST_DATA1: begin
                        if (status_vld_q) begin
                            if (two_byte_s) begin
                                data1_d = rx_byte;
                                state_d = ST_DATA2;
                            end else begin
                                emit_s    = 1'b1;
                                emit_b1_s = rx_byte;
                                emit_b2_s = 8'h00;
                            end
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DATA2: begin
                        emit_s    = 1'b1;
                        emit_b1_s = data1_q;
                        emit_b2_s = rx_byte;
                    end
                    ST_SYSEX: begin
                        state_d = ST_SYSEX;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else if (rx_byte >= 8'hF8) begin
                // Realtime bytes pass through without disturbing the parse.
                state_d = state_q;
            end else if (rx_byte == 8'hF0) begin
                state_d      = ST_SYSEX;
                status_vld_d = 1'b0;
            end else if (rx_byte >= 8'hF1) begin
                // System common (including F7 ending a sysex) drops running status.
                state_d      = ST_IDLE;
                status_vld_d = 1'b0;
            end else begin
                // Channel status restarts a message, abandoning any partial one.
                status_d     = rx_byte;
                status_vld_d = 1'b1;
                state_d      = ST_DATA1;
            end
        end else begin
            state_d = state_q;
        end

        if (emit_s) begin
            if (CHANNEL_MASK[status_q[3:0]]) begin
                message_d.channel    = status_q[3:0];
                message_d.data_byte1 = emit_b1_s;
                message_d.data_byte2 = emit_b2_s;
                // Note-on with zero velocity is by convention a note-off.
                if ((status_q[7:4] == 4'h9) && (emit_b2_s == 8'h00)) begin
                    message_d.message_type = MIDI::NOTE_OFF;
                end else begin
                    message_d.message_type = type_of(status_q[7:4]);
                end
                message_ready_d = 1'b1;
            end else begin
                message_ready_d = 1'b0;
            end
`ifdef MIDI_RUNNING_STATUS_EN
            state_d      = ST_DATA1;
            status_vld_d = 1'b1;
`else
            state_d      = ST_IDLE;
            status_vld_d = 1'b0;
`endif
        end else begin
            emit_s = 1'b0;
        end
    end

    // Parser and output registers, cleared asynchronously by reset_l.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state_q         <= ST_IDLE;
            status_q        <= 8'h00;
            status_vld_q    <= 1'b0;
            data1_q         <= 8'h00;
            message_q       <= '0;
            message_ready_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            status_q        <= status_d;
            status_vld_q    <= status_vld_d;
            data1_q         <= data1_d;
            message_q       <= message_d;
            message_ready_q <= message_ready_d;
        end
    end

    assign message       = message_q;
    assign message_ready = message_ready_q;

endmodule

// File: tb/tb_midi_decoder.sv
// Directed bench for midi_decoder: an all-channel instance (dut_a) and a
// channel-0-only instance (dut_b) see the same byte stream.
module tb_midi_decoder;

    logic           clk = 1'b0;
    logic           reset_l;
    logic [7:0]     rx_byte;
    logic           rx_valid;
    MIDI::message_t msg_a, msg_b, exp_m;
    logic           rdy_a, rdy_b;
    int             checks = 0;
    int             failures = 0;
    int             cnt_a = 0;
    int             cnt_b = 0;

    always #10 clk = ~clk;

    midi_decoder dut_a (
        .clock_50_000_000(clk),
        .reset_l(reset_l),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .message(msg_a),
        .message_ready(rdy_a)
    );

    midi_decoder #(.CHANNEL_MASK(16'h0001)) dut_b (
        .clock_50_000_000(clk),
        .reset_l(reset_l),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .message(msg_b),
        .message_ready(rdy_b)
    );

    // Strobe counters: message_ready is high across exactly one falling edge.
    always @(negedge clk) begin
        if (rdy_a) cnt_a <= cnt_a + 1;
        if (rdy_b) cnt_b <= cnt_b + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        #1;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        @(posedge clk);
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic test_reset();
        reset_l  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        #5;
        checks++; if (msg_a !== '0) begin failures++; $display("FAIL reset_msg: got %h expected 0", msg_a); end
        checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", rdy_a); end
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        clear_counts();
        send_byte(8'h3C);
        send_byte(8'h64);
        settle();
        checks++; if (cnt_a != 0) begin failures++; $display("FAIL reset_drop: got %0d strobes expected 0", cnt_a); end
    endtask

    task automatic test_note_on();
        clear_counts();
        send_byte(8'h90);
        send_byte(8'h3C);
        checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL note_on_early: got %b expected 0", rdy_a); end
        send_byte(8'h64);
        exp_m = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 8'h3C, data_byte2: 8'h64};
        checks++; if (rdy_a !== 1'b1) begin failures++; $display("FAIL note_on_latency: got %b expected 1", rdy_a); end
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL note_on_msg: got %h expected %h", msg_a, exp_m); end
        @(negedge clk); #1;
        checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL note_on_width: got %b expected 0", rdy_a); end
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL note_on_hold: got %h expected %h", msg_a, exp_m); end
        settle();
        checks++; if (cnt_a != 1) begin failures++; $display("FAIL note_on_count: got %0d expected 1", cnt_a); end
    endtask

    task automatic test_note_off_vel0();
        clear_counts();
        send_byte(8'h92);
        send_byte(8'h40);
        send_byte(8'h00);
        exp_m = '{message_type: MIDI::NOTE_OFF, channel: 4'd2, data_byte1: 8'h40, data_byte2: 8'h00};
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL vel0_msg: got %h expected %h", msg_a, exp_m); end
        settle();
        exp_m = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 8'h3C, data_byte2: 8'h64};
        checks++; if (cnt_b != 0) begin failures++; $display("FAIL vel0_mask_count: got %0d expected 0", cnt_b); end
        checks++; if (msg_b !== exp_m) begin failures++; $display("FAIL vel0_mask_hold: got %h expected %h", msg_b, exp_m); end
    endtask

    task automatic test_realtime();
        clear_counts();
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF8);
        checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL rt_early: got %b expected 0", rdy_a); end
        send_byte(8'h64);
        exp_m = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 8'h3C, data_byte2: 8'h64};
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL rt_msg: got %h expected %h", msg_a, exp_m); end
        settle();
        checks++; if (cnt_a != 1) begin failures++; $display("FAIL rt_count: got %0d expected 1", cnt_a); end
    endtask

    task automatic test_sysex();
        clear_counts();
        send_byte(8'hF0);
        send_byte(8'h7E);
        send_byte(8'h01);
        send_byte(8'hF7);
        settle();
        checks++; if (cnt_a != 0) begin failures++; $display("FAIL sysex_quiet: got %0d strobes expected 0", cnt_a); end
        send_byte(8'hC5);
        send_byte(8'h07);
        exp_m = '{message_type: MIDI::PROGRAM_CHANGE, channel: 4'd5, data_byte1: 8'h07, data_byte2: 8'h00};
        checks++; if (rdy_a !== 1'b1) begin failures++; $display("FAIL sysex_pc_rdy: got %b expected 1", rdy_a); end
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL sysex_pc_msg: got %h expected %h", msg_a, exp_m); end
    endtask

    task automatic test_status_handling();
        // System common clears the status mid-message.
        clear_counts();
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF6);
        send_byte(8'h64);
        settle();
        checks++; if (cnt_a != 0) begin failures++; $display("FAIL syscommon_clear: got %0d strobes expected 0", cnt_a); end
        // A new status in DATA2 abandons the partial note.
        clear_counts();
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hB1);
        send_byte(8'h07);
        send_byte(8'h7F);
        exp_m = '{message_type: MIDI::CONTROL_CHANGE, channel: 4'd1, data_byte1: 8'h07, data_byte2: 8'h7F};
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL abandon_msg: got %h expected %h", msg_a, exp_m); end
        settle();
        checks++; if (cnt_a != 1) begin failures++; $display("FAIL abandon_count: got %0d expected 1", cnt_a); end
        send_byte(8'hE3);
        send_byte(8'h00);
        send_byte(8'h40);
        exp_m = '{message_type: MIDI::PITCH_BEND, channel: 4'd3, data_byte1: 8'h00, data_byte2: 8'h40};
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL pitch_bend_msg: got %h expected %h", msg_a, exp_m); end
        send_byte(8'hD2);
        send_byte(8'h33);
        exp_m = '{message_type: MIDI::CHANNEL_PRESSURE, channel: 4'd2, data_byte1: 8'h33, data_byte2: 8'h00};
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL chan_press_msg: got %h expected %h", msg_a, exp_m); end
    endtask

    task automatic test_back_to_back();
        int exp_cnt;
        clear_counts();
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'h64);
        send_byte(8'h3E);
        send_byte(8'h50);
`ifdef MIDI_RUNNING_STATUS_EN
        exp_cnt = 2;
        exp_m = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 8'h3E, data_byte2: 8'h50};
`else
        exp_cnt = 1;
        exp_m = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 8'h3C, data_byte2: 8'h64};
`endif
        checks++; if (msg_a !== exp_m) begin failures++; $display("FAIL running_msg: got %h expected %h", msg_a, exp_m); end
        settle();
        checks++; if (cnt_a != exp_cnt) begin failures++; $display("FAIL running_count: got %0d expected %0d", cnt_a, exp_cnt); end
    endtask

    task automatic test_channel_mask();
        MIDI::message_t held_b;
        clear_counts();
        send_byte(8'h90);
        send_byte(8'h11);
        send_byte(8'h22);
        held_b = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 8'h11, data_byte2: 8'h22};
        checks++; if (msg_b !== held_b) begin failures++; $display("FAIL mask_ch0_msg: got %h expected %h", msg_b, held_b); end
        clear_counts();
        send_byte(8'h91);
        send_byte(8'h3C);
        send_byte(8'h64);
        settle();
        checks++; if (cnt_b != 0) begin failures++; $display("FAIL mask_ch1_count: got %0d expected 0", cnt_b); end
        checks++; if (msg_b !== held_b) begin failures++; $display("FAIL mask_ch1_hold: got %h expected %h", msg_b, held_b); end
        checks++; if (cnt_a != 1) begin failures++; $display("FAIL open_ch1_count: got %0d expected 1", cnt_a); end
        // Reset in the middle of 90 3C .. 64 discards the partial note.
        clear_counts();
        send_byte(8'h90);
        send_byte(8'h3C);
        @(negedge clk);
        reset_l = 1'b0;
        #1;
        checks++; if (msg_a !== '0) begin failures++; $display("FAIL async_reset_msg: got %h expected 0", msg_a); end
        @(negedge clk);
        reset_l = 1'b1;
        send_byte(8'h64);
        settle();
        checks++; if (cnt_a != 0) begin failures++; $display("FAIL reset_partial_a: got %0d strobes expected 0", cnt_a); end
        checks++; if (cnt_b != 0) begin failures++; $display("FAIL reset_partial_b: got %0d strobes expected 0", cnt_b); end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_note_off_vel0();
        test_realtime();
        test_sysex();
        test_status_handling();
        test_back_to_back();
        test_channel_mask();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
